// File: rtl/modulo_emulador_pkg.sv
// Shared constants for the bottle plant emulator: state encoding, counter widths, phase limit select.
// Latency: n/a (package only).
// Backpressure: n/a.
package modulo_emulador_pkg;

    localparam int CNT_W = 8;
    localparam int VED_W = 8;

    typedef enum logic [1:0] {
        ST_MOVER  = 2'd0,
        ST_ENCHER = 2'd1,
        ST_VEDAR  = 2'd2,
        ST_SAIR   = 2'd3
    } estado_t;

    // Terminal value (T-1) for the phase that owns the shared counter; ST_SAIR never counts.
    function automatic logic [CNT_W-1:0] limite_fase(
        input estado_t st,
        input int      t_transporte,
        input int      t_encher,
        input int      t_vedar
    );
        logic [CNT_W-1:0] lim;
        lim = '0;
        case (st)
            ST_MOVER:  lim = CNT_W'(t_transporte - 1);
            ST_ENCHER: lim = CNT_W'(t_encher - 1);
            ST_VEDAR:  lim = CNT_W'(t_vedar - 1);
            default:   lim = '0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/modulo_emulador_linha_garrafas_contador.sv
// Phase counter shared by all plant phases: count enable, sync clear, terminal compare.
// Latency: count updates on the edge after en; fim is combinational from cnt.
// Backpressure: none; en simply holds the count when low.
module modulo_contador_fase
    import modulo_emulador_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sclr,
    input  logic [CNT_W-1:0] limite,
    output logic [CNT_W-1:0] cnt,
    output logic             fim
);

    assign fim = (cnt == limite);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
        end else if (sclr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/modulo_emulador_linha_garrafas.sv
// Bottle conveyor/filler/sealer plant emulator; optional misuse flag under EMULADOR_ERRO_EN.
// Latency: sensors follow the registered state one edge after the qualifying command.
// Backpressure: none; commands are sampled every cycle, absent commands stall the phase.
module modulo_emulador_linha_garrafas
    import modulo_emulador_pkg::*;
#(
    parameter int T_TRANSPORTE = 8,
    parameter int T_ENCHER     = 6,
    parameter int T_VEDAR      = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             m,
    input  logic             ev,
    input  logic             ve,
    output logic             pg,
    output logic             ch,
    output logic             cq,
    output logic [VED_W-1:0] vedadas,
    output logic             erro
);

    estado_t          estado;
    logic             cnt_en;
    logic             cnt_sclr;
    logic             cnt_fim;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limite;
    logic             fase_fim;

    always_comb begin
        cnt_en = 1'b0;
        case (estado)
            ST_MOVER:  cnt_en = m;
            ST_ENCHER: cnt_en = ev;
            ST_VEDAR:  cnt_en = ve;
            default:   cnt_en = 1'b0;
        endcase
    end

    assign limite   = limite_fase(estado, T_TRANSPORTE, T_ENCHER, T_VEDAR);
    assign fase_fim = cnt_en && cnt_fim;
    assign cnt_sclr = fase_fim || ((estado == ST_SAIR) && m);

    modulo_contador_fase u_contador (
        .clk    (clk),
        .clr    (clr),
        .en     (cnt_en),
        .sclr   (cnt_sclr),
        .limite (limite),
        .cnt    (cnt),
        .fim    (cnt_fim)
    );

    // Moore sensors straight from the state register.
    assign pg = (estado != ST_MOVER);
    assign ch = (estado == ST_VEDAR) || (estado == ST_SAIR);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            estado  <= ST_MOVER;
            cq      <= 1'b0;
            vedadas <= '0;
        end else begin
            cq <= 1'b0;
            case (estado)
                ST_MOVER: begin
                    if (fase_fim) estado <= ST_ENCHER;
                end
                ST_ENCHER: begin
                    if (fase_fim) estado <= ST_VEDAR;
                end
                ST_VEDAR: begin
                    if (fase_fim) begin
                        estado  <= ST_SAIR;
                        cq      <= 1'b1;
                        vedadas <= vedadas + 1'b1;
                    end
                end
                ST_SAIR: begin
                    if (m) estado <= ST_MOVER;
                end
                default: estado <= ST_MOVER;
            endcase
        end
    end

`ifdef EMULADOR_ERRO_EN
    logic uso_indevido;
    logic erro_q;

    // Spill: valve open without a bottle being filled; drag: conveyor moved mid-process.
    assign uso_indevido = (ev && (estado != ST_ENCHER)) ||
                          (m && ((estado == ST_ENCHER) || (estado == ST_VEDAR)));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            erro_q <= 1'b0;
        end else if (uso_indevido) begin
            erro_q <= 1'b1;
        end
    end

    assign erro = erro_q;
`else
    assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_modulo_emulador_linha_garrafas.sv
// Scoreboard bench for the bottle plant emulator with a phase-progress reference model.
module tb_modulo_emulador_linha_garrafas;

    localparam int TT = 4;
    localparam int TE = 3;
    localparam int TV = 2;
`ifdef EMULADOR_ERRO_EN
    localparam logic ERRO_ON = 1'b1;
`else
    localparam logic ERRO_ON = 1'b0;
`endif

    typedef struct packed {
        logic       pg;
        logic       ch;
        logic       cq;
        logic [7:0] ved;
        logic       erro;
    } saida_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       m, ev, ve;
    logic       pg, ch, cq, erro;
    logic [7:0] vedadas;

    int checks = 0;
    int errors = 0;

    saida_t fila[$];

    // Reference model: which step of the bottle recipe we are in and how many
    // useful command cycles that step has accumulated.
    int   fase;
    int   prog;
    int   selados;
    logic m_erro;
    logic m_cq;

    modulo_emulador_linha_garrafas #(
        .T_TRANSPORTE (TT),
        .T_ENCHER     (TE),
        .T_VEDAR      (TV)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .m       (m),
        .ev      (ev),
        .ve      (ve),
        .pg      (pg),
        .ch      (ch),
        .cq      (cq),
        .vedadas (vedadas),
        .erro    (erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nome, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fase    = 0;
        prog    = 0;
        selados = 0;
        m_erro  = 1'b0;
        m_cq    = 1'b0;
    endtask

    task automatic step(input logic mi, input logic evi, input logic vei);
        int need;
        m  = mi;
        ev = evi;
        ve = vei;
        if (ERRO_ON && ((evi && fase != 1) || (mi && (fase == 1 || fase == 2))))
            m_erro = 1'b1;
        m_cq = 1'b0;
        need = (fase == 0) ? TT : (fase == 1) ? TE : TV;
        if ((fase == 0 && mi) || (fase == 1 && evi) || (fase == 2 && vei)) begin
            prog++;
            if (prog == need) begin
                prog = 0;
                if (fase == 2) begin
                    m_cq    = 1'b1;
                    selados = (selados + 1) % 256;
                end
                fase = fase + 1;
            end
        end else if (fase == 3 && mi) begin
            fase = 0;
            prog = 0;
        end
        fila.push_back({logic'(fase != 0), logic'(fase >= 2), m_cq, 8'(selados), m_erro});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic garrafa();
        repeat (TT) step(1, 0, 0);
        repeat (TE) step(0, 1, 0);
        repeat (TV) step(0, 0, 1);
        step(1, 0, 0);
    endtask

    task automatic reset_meio();
        #2;
        clr = 1'b0;
        m = 1'b0; ev = 1'b0; ve = 1'b0;
        #1;
        chk("rst_pg", {7'd0, pg}, 8'd0);
        chk("rst_ch", {7'd0, ch}, 8'd0);
        chk("rst_cq", {7'd0, cq}, 8'd0);
        chk("rst_vedadas", vedadas, 8'd0);
        chk("rst_erro", {7'd0, erro}, 8'd0);
        model_reset();
        #1;
        clr = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every output sample after an edge is checked against the oldest expectation.
    initial begin
        saida_t exp_s;
        saida_t act_s;
        forever begin
            @(posedge clk);
            #1;
            if (fila.size() > 0) begin
                exp_s = fila.pop_front();
                act_s = {pg, ch, cq, vedadas, erro};
                checks++;
                if (act_s !== exp_s) begin
                    errors++;
                    $display("FAIL saida t=%0t: got pg=%b ch=%b cq=%b ved=%0d erro=%b expected pg=%b ch=%b cq=%b ved=%0d erro=%b",
                             $time, act_s.pg, act_s.ch, act_s.cq, act_s.ved, act_s.erro,
                             exp_s.pg, exp_s.ch, exp_s.cq, exp_s.ved, exp_s.erro);
                end
            end
        end
    end

    initial begin
        clr = 1'b0;
        m = 1'b0; ev = 1'b0; ve = 1'b0;
        model_reset();
        #3;
        chk("init_pg", {7'd0, pg}, 8'd0);
        chk("init_ch", {7'd0, ch}, 8'd0);
        chk("init_cq", {7'd0, cq}, 8'd0);
        chk("init_vedadas", vedadas, 8'd0);
        chk("init_erro", {7'd0, erro}, 8'd0);
        @(negedge clk);
        clr = 1'b1;

        // Full cycle
        repeat (TT - 1) step(1, 0, 0);
        chk("full_pg_before", {7'd0, pg}, 8'd0);
        step(1, 0, 0);
        chk("full_pg_at4", {7'd0, pg}, 8'd1);
        step(0, 0, 0);
        repeat (TE) step(0, 1, 0);
        chk("full_ch", {7'd0, ch}, 8'd1);
        repeat (TV) step(0, 0, 1);
        chk("full_cq", {7'd0, cq}, 8'd1);
        chk("full_vedadas", vedadas, 8'd1);
        step(1, 0, 0);
        chk("full_cq_drop", {7'd0, cq}, 8'd0);
        chk("full_pg_exit", {7'd0, pg}, 8'd0);

        // Gapped motor
        repeat (2) step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        chk("gap_pg_3rd", {7'd0, pg}, 8'd0);
        step(1, 0, 0);
        chk("gap_pg_4th", {7'd0, pg}, 8'd1);

        // Reset mid-fill
        step(0, 1, 0);
        reset_meio();

        // Wrap over 256 bottles from a clean start
        for (int b = 1; b <= 256; b++) begin
            garrafa();
            if (b == 255) chk("wrap_255", vedadas, 8'd255);
        end
        chk("wrap_0", vedadas, 8'd0);
        chk("wrap_erro", {7'd0, erro}, 8'd0);

        // Drag in the sealing phase
        reset_meio();
        repeat (TT) step(1, 0, 0);
        repeat (TE) step(0, 1, 0);
        step(1, 0, 0);
        chk("drag_erro", {7'd0, erro}, {7'd0, ERRO_ON});
        chk("drag_ch_held", {7'd0, ch}, 8'd1);
        repeat (TV) step(0, 0, 1);
        chk("drag_cq", {7'd0, cq}, 8'd1);
        step(1, 0, 0);

        // Spill while moving, then a clean bottle: flag must stick
        reset_meio();
        step(0, 1, 0);
        step(0, 0, 0);
        chk("spill_erro", {7'd0, erro}, {7'd0, ERRO_ON});
        garrafa();
        chk("spill_sticky", {7'd0, erro}, {7'd0, ERRO_ON});

        // Randomized commands, mostly recipe-appropriate with gaps and misuse
        reset_meio();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic cm, cev, cve;
            r = $urandom_range(0, 9);
            cm = 1'b0; cev = 1'b0; cve = 1'b0;
            if (r < 6) begin
                case (fase)
                    0: cm  = 1'b1;
                    1: cev = 1'b1;
                    2: cve = 1'b1;
                    default: cm = 1'b1;
                endcase
            end else if (r < 9) begin
                cve = 1'($urandom_range(0, 1));
            end else begin
                cm  = 1'($urandom_range(0, 1));
                cev = 1'($urandom_range(0, 1));
                cve = 1'($urandom_range(0, 1));
            end
            step(cm, cev, cve);
            if (i == 1500) reset_meio();
        end

        step(0, 0, 0);
        @(posedge clk);
        #2;
        checks++;
        if (fila.size() != 0) begin
            errors++;
            $display("FAIL fila_vazia: got %0d pending expected 0", fila.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
